// File: rtl/mem_access_unit_pkg.sv
// Shared opcodes, access-size and FSM encodings, and the opcode decoder for mem_access_unit.
// Latency: none, declarations and a pure function only.
// Backpressure: not applicable.
package mem_access_unit_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LL  = 6'h30;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SC  = 6'h38;

  // Encoding is fixed: other blocks compare against these raw values.
  typedef enum logic [1:0] {
    SZ_COND = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Decoded operation; sc counts as a store so a misaligned sc reports ades.
  typedef struct packed {
    size_e size;
    logic  store;
    logic  sgn;
    logic  ll;
    logic  sc;
  } op_t;

  // Unknown opcodes fall through as a plain word load.
  function automatic op_t decode_op(input logic [5:0] opc);
    op_t d;
    d.size  = SZ_WORD;
    d.store = 1'b0;
    d.sgn   = 1'b0;
    d.ll    = 1'b0;
    d.sc    = 1'b0;
    case (opc)
      OP_LB:  begin d.size = SZ_BYTE; d.sgn = 1'b1; end
      OP_LBU: d.size = SZ_BYTE;
      OP_LH:  begin d.size = SZ_HALF; d.sgn = 1'b1; end
      OP_LHU: d.size = SZ_HALF;
      OP_LL:  d.ll = 1'b1;
      OP_SB:  begin d.size = SZ_BYTE; d.store = 1'b1; end
      OP_SH:  begin d.size = SZ_HALF; d.store = 1'b1; end
      OP_SW:  d.store = 1'b1;
      OP_SC:  begin d.size = SZ_COND; d.store = 1'b1; d.sc = 1'b1; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Pipeline-side and bus-side handshake bundles for mem_access_unit.
// Latency: none, wiring only.
// Backpressure: pipe uses valid/ready on both request and response; bus uses addr_ok/data_ok.
// Ports: mem_pipe_if  master = pipeline, slave = access unit
//        mem_bus_if   master = access unit, slave = data SRAM bus
interface mem_pipe_if #(parameter int ADDR_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [5:0]        in_opcode;
  logic [ADDR_W-1:0] in_addr;
  logic [31:0]       in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_rdata;
  logic              out_adel;
  logic              out_ades;
  logic [ADDR_W-1:0] out_badvaddr;

  modport master (
    output in_valid, in_opcode, in_addr, in_wdata, out_ready,
    input  in_ready, out_valid, out_rdata, out_adel, out_ades, out_badvaddr
  );
  modport slave (
    input  in_valid, in_opcode, in_addr, in_wdata, out_ready,
    output in_ready, out_valid, out_rdata, out_adel, out_ades, out_badvaddr
  );
endinterface

interface mem_bus_if #(parameter int ADDR_W = 32);
  logic              m_req;
  logic              m_wr;
  logic [3:0]        m_be;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata;
  logic              m_addr_ok;
  logic              m_data_ok;
  logic [31:0]       m_rdata;

  modport master (
    output m_req, m_wr, m_be, m_addr, m_wdata,
    input  m_addr_ok, m_data_ok, m_rdata
  );
  modport slave (
    input  m_req, m_wr, m_be, m_addr, m_wdata,
    output m_addr_ok, m_data_ok, m_rdata
  );
endinterface

// File: rtl/mem_access_unit_lane.sv
// Byte-lane steering: byte enables, replicated store data, extracted/extended load data, misalign flag.
// Latency: combinational.
// Backpressure: none.
// Ports: size_i/addr_lo_i/sgn_i select the access; wdata_i/rdata_i raw data; be_o, wdata_o, rdata_o, misalign_o results.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sgn_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [31:0] lane;

  // Move the addressed lane down to bit 0 before extension.
  assign lane = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    rdata_o    = rdata_i;
    misalign_o = |addr_lo_i;
    case (size_i)
      SZ_BYTE: begin
        be_o       = 4'b0001 << addr_lo_i;
        wdata_o    = {4{wdata_i[7:0]}};
        rdata_o    = {{24{sgn_i & lane[7]}}, lane[7:0]};
        misalign_o = 1'b0;
      end
      SZ_HALF: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{sgn_i & lane[15]}}, lane[15:0]};
        misalign_o = addr_lo_i[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-cycle data-memory access unit: decode, align check, bus handshake, load extension, LL/SC link.
// Latency: 3 cycles accept-to-response best case (2 if addr_ok and data_ok coincide), 1 for errors / failed sc.
// Backpressure: one request in flight; in_ready only in IDLE, response held until out_ready.
// Ports: clk, rst (async, active-high), llbit_clr, pipe (mem_pipe_if.slave), bus (mem_bus_if.master).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter bit LLSC_EN = 1'b1
)(
  input  logic        clk,
  input  logic        rst,
  input  logic        llbit_clr,
  mem_pipe_if.slave   pipe,
  mem_bus_if.master   bus
);

  state_e              state_q, state_d;
  op_t                 op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         result_q;
  logic                adel_q, ades_q;
  logic                llbit_q;
  logic [ADDR_W-3:0]   lladdr_q;

  op_t                 in_dec;
  logic                accept, link_ok, sc_fail, data_done, in_req;
  size_e               ln_size;
  logic [1:0]          ln_addr_lo;
  logic                ln_sgn;
  logic [31:0]         ln_wdata;
  logic [3:0]          ln_be;
  logic [31:0]         ln_wdata_sh, ln_rdata_ext;
  logic                ln_misalign;

  assign in_dec    = decode_op(pipe.in_opcode);
  assign accept    = (state_q == ST_IDLE) && pipe.in_valid;
  assign in_req    = (state_q == ST_REQ);
  assign link_ok   = !LLSC_EN || (llbit_q && (pipe.in_addr[ADDR_W-1:2] == lladdr_q));
  assign sc_fail   = in_dec.sc && !link_ok;
  assign data_done = (in_req && bus.m_addr_ok && bus.m_data_ok) ||
                     ((state_q == ST_WAIT) && bus.m_data_ok);

  // One aligner serves both phases: in IDLE it checks the incoming request,
  // afterwards it steers the captured request and the returning bus data.
  assign ln_size    = (state_q == ST_IDLE) ? in_dec.size         : op_q.size;
  assign ln_addr_lo = (state_q == ST_IDLE) ? pipe.in_addr[1:0]   : addr_q[1:0];
  assign ln_sgn     = (state_q == ST_IDLE) ? in_dec.sgn          : op_q.sgn;
  assign ln_wdata   = (state_q == ST_IDLE) ? pipe.in_wdata       : wdata_q;

  mem_lane_align u_lane (
    .size_i     (ln_size),
    .addr_lo_i  (ln_addr_lo),
    .sgn_i      (ln_sgn),
    .wdata_i    (ln_wdata),
    .rdata_i    (bus.m_rdata),
    .be_o       (ln_be),
    .wdata_o    (ln_wdata_sh),
    .rdata_o    (ln_rdata_ext),
    .misalign_o (ln_misalign)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pipe.in_valid) state_d = (ln_misalign || sc_fail) ? ST_RESP : ST_REQ;
      ST_REQ:  if (bus.m_addr_ok) state_d = bus.m_data_ok ? ST_RESP : ST_WAIT;
      ST_WAIT: if (bus.m_data_ok) state_d = ST_RESP;
      ST_RESP: if (pipe.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs; bus fields are forced to zero outside REQ so m_req drops with rst.
  always_comb begin
    pipe.in_ready     = (state_q == ST_IDLE);
    pipe.out_valid    = (state_q == ST_RESP);
    pipe.out_rdata    = result_q;
    pipe.out_adel     = adel_q;
    pipe.out_ades     = ades_q;
    pipe.out_badvaddr = addr_q;
    bus.m_req         = in_req;
    bus.m_wr          = in_req && op_q.store;
    bus.m_be          = in_req ? ln_be : 4'b0000;
    bus.m_addr        = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    bus.m_wdata       = (in_req && op_q.store) ? ln_wdata_sh : 32'd0;
  end

  // Request capture and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      result_q <= '0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
    end else if (accept) begin
      op_q     <= in_dec;
      addr_q   <= pipe.in_addr;
      wdata_q  <= pipe.in_wdata;
      result_q <= '0;
      adel_q   <= ln_misalign && !in_dec.store;
      ades_q   <= ln_misalign && in_dec.store;
    end else if (data_done) begin
      result_q <= op_q.store ? {31'd0, op_q.sc} : ln_rdata_ext;
    end
  end

  // Link register. The sc outcome is fixed at acceptance, so the link can be
  // dropped there; an external clear beats an ll completing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      llbit_q  <= 1'b0;
      lladdr_q <= '0;
    end else if (llbit_clr || (accept && in_dec.sc)) begin
      llbit_q  <= 1'b0;
    end else if (LLSC_EN && data_done && op_q.ll) begin
      llbit_q  <= 1'b1;
      lladdr_q <= addr_q[ADDR_W-1:2];
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic llbit_clr = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mem_pipe_if #(.ADDR_W(32)) pipe();
  mem_bus_if  #(.ADDR_W(32)) bus();

  mem_access_unit #(.ADDR_W(32), .LLSC_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .llbit_clr (llbit_clr),
    .pipe      (pipe),
    .bus       (bus)
  );

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;     // bus read data returned
    int          addr_dly;  // cycles m_req is held before addr_ok
    bit          together;  // addr_ok and data_ok in same cycle
    bit          pre_clr;   // llbit_clr pulse before issuing
    bit          clr_done;  // llbit_clr together with data_ok
    int          hold;      // cycles out_ready stays low in RESP
    bit          exp_bus;
    bit          exp_wr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_out;
    bit          exp_adel;
    bit          exp_ades;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int  req_cnt = 0;
    int  lat = 0;
    bit  bus_seen = 1'b0;
    bit  pending = 1'b0;
    bit  done = 1'b0;
    if (v.pre_clr) begin
      llbit_clr = 1'b1;
      @(posedge clk); @(negedge clk);
      llbit_clr = 1'b0;
    end
    pipe.out_ready = (v.hold == 0);
    chk({nm, ":in_ready_idle"}, {31'd0, pipe.in_ready}, 32'd1);
    pipe.in_valid  = 1'b1;
    pipe.in_opcode = v.op;
    pipe.in_addr   = v.addr;
    pipe.in_wdata  = v.wdata;
    @(posedge clk); @(negedge clk);
    pipe.in_valid  = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      bus.m_addr_ok = 1'b0;
      bus.m_data_ok = 1'b0;
      llbit_clr     = 1'b0;
      if (pipe.out_valid) begin
        lat  = c;
        done = 1'b1;
      end else begin
        chk({nm, ":in_ready_busy"}, {31'd0, pipe.in_ready}, 32'd0);
        if (bus.m_req) begin
          bus_seen = 1'b1;
          req_cnt++;
          chk({nm, ":m_addr"}, bus.m_addr, {v.addr[31:2], 2'b00});
          chk({nm, ":m_be"}, {28'd0, bus.m_be}, {28'd0, v.exp_be});
          chk({nm, ":m_wr"}, {31'd0, bus.m_wr}, {31'd0, v.exp_wr});
          if (v.exp_wr) chk({nm, ":m_wdata"}, bus.m_wdata, v.exp_wdata);
          if (req_cnt > v.addr_dly) begin
            bus.m_addr_ok = 1'b1;
            if (v.together) begin
              bus.m_data_ok = 1'b1;
              bus.m_rdata   = v.rdata;
              llbit_clr     = v.clr_done;
            end else begin
              pending = 1'b1;
            end
          end
        end else if (pending) begin
          bus.m_data_ok = 1'b1;
          bus.m_rdata   = v.rdata;
          llbit_clr     = v.clr_done;
          pending       = 1'b0;
        end
        @(posedge clk); @(negedge clk);
      end
    end
    chk({nm, ":latency"}, lat, v.exp_lat);
    chk({nm, ":bus_used"}, {31'd0, bus_seen}, {31'd0, v.exp_bus});
    chk({nm, ":req_cycles"}, req_cnt, v.exp_bus ? v.addr_dly + 1 : 0);
    chk({nm, ":rdata"}, pipe.out_rdata, v.exp_out);
    chk({nm, ":adel"}, {31'd0, pipe.out_adel}, {31'd0, v.exp_adel});
    chk({nm, ":ades"}, {31'd0, pipe.out_ades}, {31'd0, v.exp_ades});
    chk({nm, ":badvaddr"}, pipe.out_badvaddr, v.addr);
    if (v.hold > 0) begin
      for (int h = 0; h < v.hold; h++) begin
        // Stray data_ok during RESP must be ignored.
        bus.m_data_ok = 1'b1;
        bus.m_rdata   = ~v.rdata;
        @(posedge clk); @(negedge clk);
        chk({nm, ":hold_valid"}, {31'd0, pipe.out_valid}, 32'd1);
        chk({nm, ":hold_rdata"}, pipe.out_rdata, v.exp_out);
        chk({nm, ":hold_in_ready"}, {31'd0, pipe.in_ready}, 32'd0);
      end
      bus.m_data_ok  = 1'b0;
      pipe.out_ready = 1'b1;
    end
    @(posedge clk); @(negedge clk);
    chk({nm, ":handoff_valid"}, {31'd0, pipe.out_valid}, 32'd0);
  endtask

  vec_t tbl [22];
  vec_t v;

  initial begin
    //          op      addr          wdata         rdata         dly tg pc cd hd bus wr be       wdata         out           adel ades lat
    tbl[0]  = '{OP_SB,  32'h0000_1003, 32'h0000_00A5, 32'h0,        0, 0, 0, 0, 0, 1, 1, 4'b1000, 32'hA5A5_A5A5, 32'h0,        0, 0, 3};
    tbl[1]  = '{OP_LH,  32'h0000_2002, 32'h0,        32'h8001_1234, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 0, 0, 3};
    tbl[2]  = '{OP_LHU, 32'h0000_2002, 32'h0,        32'h8001_1234, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 32'h0,        32'h0000_8001, 0, 0, 3};
    tbl[3]  = '{OP_LW,  32'h0000_3001, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 0, 1};
    tbl[4]  = '{OP_LL,  32'h0000_4000, 32'h0,        32'hDEAD_BEEF, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 32'h0,        32'hDEAD_BEEF, 0, 0, 3};
    tbl[5]  = '{OP_SC,  32'h0000_4000, 32'h1234_5678, 32'h0,        0, 0, 0, 0, 0, 1, 1, 4'b1111, 32'h1234_5678, 32'h1,        0, 0, 3};
    tbl[6]  = '{OP_SC,  32'h0000_4000, 32'h1234_5678, 32'h0,        0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 1};
    tbl[7]  = '{OP_SH,  32'h0000_5001, 32'h0000_0001, 32'h0,        0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 1};
    tbl[8]  = '{OP_LB,  32'h0000_6001, 32'h0,        32'h0000_8000, 0, 0, 0, 0, 0, 1, 0, 4'b0010, 32'h0,        32'hFFFF_FF80, 0, 0, 3};
    tbl[9]  = '{OP_LBU, 32'h0000_6001, 32'h0,        32'h0000_8000, 0, 0, 0, 0, 0, 1, 0, 4'b0010, 32'h0,        32'h0000_0080, 0, 0, 3};
    tbl[10] = '{6'h3f,  32'h0000_7000, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 32'h0,        32'hCAFE_F00D, 0, 0, 3};
    tbl[11] = '{OP_SH,  32'h0000_8002, 32'h0000_BEEF, 32'h0,        0, 0, 0, 0, 0, 1, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        0, 0, 3};
    tbl[12] = '{OP_SC,  32'h0000_9002, 32'h0,        32'h0,        0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 1, 1};
    tbl[13] = '{OP_LW,  32'h0000_A000, 32'h0,        32'h1122_3344, 0, 1, 0, 0, 0, 1, 0, 4'b1111, 32'h0,        32'h1122_3344, 0, 0, 2};
    tbl[14] = '{OP_LL,  32'h0000_4000, 32'h0,        32'h0,        0, 0, 0, 0, 0, 1, 0, 4'b1111, 32'h0,        32'h0,        0, 0, 3};
    tbl[15] = '{OP_SC,  32'h0000_4000, 32'h0000_0055, 32'h0,        0, 0, 1, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 1};
    tbl[16] = '{OP_LL,  32'h0000_4000, 32'h0,        32'h0000_0005, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 32'h0,        32'h0000_0005, 0, 0, 3};
    tbl[17] = '{OP_SC,  32'h0000_4004, 32'h0000_0055, 32'h0,        0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 1};
    tbl[18] = '{OP_LL,  32'h0000_C000, 32'h0,        32'h0000_0007, 0, 0, 0, 1, 0, 1, 0, 4'b1111, 32'h0,        32'h0000_0007, 0, 0, 3};
    tbl[19] = '{OP_SC,  32'h0000_C000, 32'h0000_0055, 32'h0,        0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 1};
    tbl[20] = '{OP_LW,  32'h0000_B004, 32'h0,        32'h0BAD_F00D, 3, 0, 0, 0, 2, 1, 0, 4'b1111, 32'h0,        32'h0BAD_F00D, 0, 0, 6};
    tbl[21] = '{OP_LB,  32'h0000_6003, 32'h0,        32'h7F00_0000, 0, 0, 0, 0, 0, 1, 0, 4'b1000, 32'h0,        32'h0000_007F, 0, 0, 3};

    pipe.in_valid  = 1'b0;
    pipe.in_opcode = '0;
    pipe.in_addr   = '0;
    pipe.in_wdata  = '0;
    pipe.out_ready = 1'b1;
    bus.m_addr_ok  = 1'b0;
    bus.m_data_ok  = 1'b0;
    bus.m_rdata    = '0;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset:in_ready",  {31'd0, pipe.in_ready},  32'd1);
    chk("reset:out_valid", {31'd0, pipe.out_valid}, 32'd0);
    chk("reset:m_req",     {31'd0, bus.m_req},      32'd0);
    chk("reset:m_wr",      {31'd0, bus.m_wr},       32'd0);
    chk("reset:m_be",      {28'd0, bus.m_be},       32'd0);
    chk("reset:m_addr",    bus.m_addr,              32'd0);
    chk("reset:m_wdata",   bus.m_wdata,             32'd0);
    chk("reset:out_rdata", pipe.out_rdata,          32'd0);
    chk("reset:adel",      {31'd0, pipe.out_adel},  32'd0);
    chk("reset:ades",      {31'd0, pipe.out_ades},  32'd0);
    chk("reset:badvaddr",  pipe.out_badvaddr,       32'd0);

    for (int i = 0; i < 22; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset during REQ: link set by ll beforehand must be gone afterwards.
    v = '{OP_LL, 32'h0000_4000, 32'h0, 32'h0000_0099, 0, 0, 0, 0, 0, 1, 0, 4'b1111, 32'h0, 32'h0000_0099, 0, 0, 3};
    run_txn(v, "rst_ll");
    pipe.in_valid  = 1'b1;
    pipe.in_opcode = OP_LW;
    pipe.in_addr   = 32'h0000_D000;
    @(posedge clk); @(negedge clk);
    pipe.in_valid  = 1'b0;
    chk("rst:m_req_before", {31'd0, bus.m_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst:m_req_async",  {31'd0, bus.m_req},      32'd0);
    chk("rst:m_addr_async", bus.m_addr,              32'd0);
    chk("rst:in_ready",     {31'd0, pipe.in_ready},  32'd1);
    chk("rst:out_valid",    {31'd0, pipe.out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    v = '{OP_SC, 32'h0000_4000, 32'h0000_0001, 32'h0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 32'h0, 32'h0, 0, 0, 1};
    run_txn(v, "rst_sc");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access unit sitting between the EX/MEM pipeline boundary and the data-SRAM bus. It decodes the memory opcode into an access size (byte, half, word, conditional), checks alignment, and generates byte enables and lane-shifted store data. It runs a request/address-ok/data-ok handshake with the bus and returns load data aligned and sign- or zero-extended. It also tracks the LL/SC link for atomic sequences.

## Interface
- ADDR_W, 32, address width; bits [1:0] select the byte lane
- LLSC_EN, 1, 1: full link tracking; 0: `sc` always succeeds and `ll` behaves as `lw`
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request from pipeline
- in_ready  out  1  unit can accept
- in_opcode  in  6  0x20 lb, 0x24 lbu, 0x21 lh, 0x25 lhu, 0x23 lw, 0x30 ll, 0x28 sb, 0x29 sh, 0x2b sw, 0x38 sc
- in_addr  in  ADDR_W  effective address
- in_wdata  in  32  store data (rt)
- out_valid  out  1  response valid
- out_ready  in  1  pipeline takes response
- out_rdata  out  32  extended load data; for `sc`, {31'b0, success}; 0 for other stores
- out_adel / out_ades  out  1  load / store address error
- out_badvaddr  out  ADDR_W  faulting address (= request address)
- llbit_clr  in  1  clears link (eret or exception)
- m_req  out  1  bus request
- m_wr  out  1  1 = write
- m_be  out  4  byte enables, little-endian
- m_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
- m_wdata  out  32  lane-shifted store data
- m_addr_ok  in  1  bus accepted address
- m_data_ok  in  1  read data valid / write done
- m_rdata  in  32  read data

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: in_ready=1. On in_valid, capture opcode, addr, wdata, decoded size.
  - Misaligned access (half with addr[0]=1, word/ll/sc with addr[1:0]≠0): go to RESP with adel (loads, ll) or ades (stores, sc). No bus access.
  - `sc` with link invalid (llbit=0 or addr[ADDR_W-1:2]≠lladdr): go to RESP with rdata=0. No bus access.
  - Otherwise: go to REQ.
- Unknown opcode: decoded as word load (legacy default).
- REQ: m_req=1, and m_req/m_wr/m_be/m_addr/m_wdata stay stable until m_addr_ok.
  - m_addr_ok alone: go to WAIT.
  - m_addr_ok and m_data_ok in the same cycle: go to RESP.
- WAIT: m_req=0. On m_data_ok, latch the processed result and go to RESP.
- RESP: out_valid=1, outputs stable until out_ready, then go to IDLE. No new acceptance in the RESP cycle.
- Byte enables:
  - byte: 1<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data: byte replicated ×4, half replicated ×2.
- Loads: extract lane by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend.
- Link register (llbit, lladdr[ADDR_W-3:0]):
  - Set on ll completion (m_data_ok).
  - Cleared on any sc completion, on llbit_clr, and on rst.
  - llbit_clr in the same cycle as an ll set: clear wins.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, m_req=0, m_wr=0, m_be=0, m_addr=0, m_wdata=0, out_rdata=0, adel=ades=0, badvaddr=0, llbit=0, lladdr=0.
- Best-case bus latency: accept at cycle 0, m_req at cycle 1 (addr_ok), data_ok at cycle 2, out_valid at cycle 3. If addr_ok and data_ok arrive together at cycle 1, out_valid is at cycle 2.
- Error or failed sc: out_valid at cycle 1.
- rst mid-transaction: m_req drops asynchronously. The bus is reset on the same rst, so no late data_ok arrives.
- out_ready held low: RESP is held indefinitely, and m_data_ok is not sampled outside WAIT/REQ.

## Structure
- mem_pkg:
  - opcode localparams
  - size enum SZ_COND=0, SZ_BYTE=1, SZ_HALF=2, SZ_WORD=3 (encoding fixed for compatibility)
  - state enum
- Sub-module mem_lane_align (combinational): size + addr[1:0] + wdata/rdata + signed flag → be, shifted wdata, extended rdata, misalign flag.

## Test plan
- sb 0xA5 @0x1003, addr_ok cycle 1, data_ok cycle 2 → m_be=4'b1000, m_wdata=0xA5A5A5A5, out_valid cycle 3.
- lh @0x2002, m_rdata=0x8001_1234 → out_rdata=0xFFFF8001; lhu same → 0x00008001.
- lw @0x3001 → out_ades=0 and out_adel=1 at cycle 1, out_badvaddr=0x3001, m_req never asserted.
- ll @0x4000 then sc @0x4000 → bus write, out_rdata=1, llbit=0. A second sc → out_rdata=0, no m_req.
- ll @0x4000, llbit_clr pulse, sc @0x4000 → out_rdata=0. Same with sc @0x4004 → 0.
- lw with addr_ok delayed 3 cycles and out_ready held low 2 cycles → m_req/m_addr stable throughout, out_rdata stable, in_ready=0 until handoff. rst asserted mid-REQ → m_req=0 immediately.
